// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Groups the hazard-detection inputs and pipeline control outputs of the
// LEGv8 front-end sequencing controller.
//   slave  : the controller (consumes *_In, drives *_Out)
//   master : the pipeline / environment (drives *_In, observes *_Out)
// Signals:
//   ifid_rn_In, ifid_rm_In   source register fields of the instruction in ID
//   idex_memRead_In          instruction in EX is a load
//   idex_rd_In               destination register of the instruction in EX
//   brTaken_In               branch resolved taken in MEM
//   imemReady_In             instruction memory data valid this cycle
//   halt_In, resume_In       HALT decoded in ID / leave the drained state
//   pcWrite_Out              PC enable
//   ifidWrite_Out            IF/ID load enable
//   ifidFlush_Out            IF/ID loads a NOP (wins over ifidWrite_Out)
//   idexBubble_Out           zero ID/EX control fields
//   exmemFlush_Out           zero EX/MEM control fields
//   state_Out                INIT=0, RUN=1, HALT=2, DRAINED=3
//   drained_Out              high while DRAINED
interface pipeline_hazard_ctrl_if;
  logic [4:0] ifid_rn_In;
  logic [4:0] ifid_rm_In;
  logic       idex_memRead_In;
  logic [4:0] idex_rd_In;
  logic       brTaken_In;
  logic       imemReady_In;
  logic       halt_In;
  logic       resume_In;
  logic       pcWrite_Out;
  logic       ifidWrite_Out;
  logic       ifidFlush_Out;
  logic       idexBubble_Out;
  logic       exmemFlush_Out;
  logic [1:0] state_Out;
  logic       drained_Out;

  modport master (
    output ifid_rn_In, ifid_rm_In, idex_memRead_In, idex_rd_In,
           brTaken_In, imemReady_In, halt_In, resume_In,
    input  pcWrite_Out, ifidWrite_Out, ifidFlush_Out, idexBubble_Out,
           exmemFlush_Out, state_Out, drained_Out
  );

  modport slave (
    input  ifid_rn_In, ifid_rm_In, idex_memRead_In, idex_rd_In,
           brTaken_In, imemReady_In, halt_In, resume_In,
    output pcWrite_Out, ifidWrite_Out, ifidFlush_Out, idexBubble_Out,
           exmemFlush_Out, state_Out, drained_Out
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the 5-stage LEGv8 pipeline front end: post-reset
// fill, taken-branch flush, load-use stall, instruction-memory wait states and
// halt/drain. State is registered; outputs are Mealy so a stall acts in the
// same cycle the hazard is seen.
// Ports:
//   clock_In   rising-edge clock
//   reset_In   synchronous active-high reset (also forces safe outputs)
//   bus        pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs)
// Optional feature macro HAZARD_STATS_EN:
//   stallCount_Out[31:0]  RUN cycles stalled by load-use or imem wait
//   flushCount_Out[31:0]  RUN cycles flushed by a taken branch
//   both saturate and clear on reset.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int XZR_IDX      = 31
) (
  input  logic                    clock_In,
  input  logic                    reset_In,
  pipeline_hazard_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stallCount_Out,
  output logic [31:0]             flushCount_Out
`endif
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_DRAINED = 2'd3
  } state_t;

  localparam logic [3:0] INIT_LOAD  = 4'(INIT_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [4:0] XZR        = 5'(XZR_IDX);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, drained;
  logic stall_evt, flush_evt;
  logic load_use;

  // XZR reads as zero, so a load "targeting" it never feeds a consumer.
  assign load_use = bus.idex_memRead_In && (bus.idex_rd_In != XZR) &&
                    ((bus.idex_rd_In == bus.ifid_rn_In) ||
                     (bus.idex_rd_In == bus.ifid_rm_In));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    drained     = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    case (state_q)
      ST_INIT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RUN: begin
        if (bus.brTaken_In) begin
          // A halt seen alongside a taken branch is on the wrong path.
          pc_write    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use) begin
          idex_bubble = 1'b1;
          stall_evt   = 1'b1;
        end else if (!bus.imemReady_In) begin
          ifid_flush  = 1'b1;
          stall_evt   = 1'b1;
        end else if (bus.halt_In) begin
          // The HALT itself retires as a bubble.
          idex_bubble = 1'b1;
          state_d     = ST_HALT;
          cnt_d       = DRAIN_LOAD;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      ST_HALT: begin
        // EX/MEM is left alone so older instructions drain to WB.
        idex_bubble = 1'b1;
        if (cnt_q == 4'd0) state_d = ST_DRAINED;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DRAINED: begin
        drained     = 1'b1;
        idex_bubble = 1'b1;
        if (bus.resume_In) state_d = ST_RUN;
      end
    endcase

    if (reset_In) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      drained     = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
    end
  end

  always_ff @(posedge clock_In) begin
    if (reset_In) begin
      state_q <= ST_INIT;
      cnt_q   <= INIT_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pcWrite_Out    = pc_write;
  assign bus.ifidWrite_Out  = ifid_write;
  assign bus.ifidFlush_Out  = ifid_flush;
  assign bus.idexBubble_Out = idex_bubble;
  assign bus.exmemFlush_Out = exmem_flush;
  assign bus.state_Out      = state_q;
  assign bus.drained_Out    = drained;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock_In) begin
    if (reset_In) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCount_Out = stall_cnt_q;
  assign flushCount_Out = flush_cnt_q;
`endif

endmodule
